// File: rtl/flexbus_pkg.sv
// Shared FlexBus definitions: FSM encoding, address window, peripheral register map.
package flexbus_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_TURN = 2'd3;

   localparam logic [31:0] FB_BASE_DEF = 32'h6000_0000;
   localparam logic [31:0] FB_WIN_MASK = 32'hF000_0000;

   localparam logic [7:0] LED_FREQ  = 8'h00;
   localparam logic [7:0] BZ_FREQ   = 8'h04;
   localparam logic [7:0] LEDR_PUTY = 8'h08;
   localparam logic [7:0] LEDG_PUTY = 8'h0C;
   localparam logic [7:0] LEDB_PUTY = 8'h10;

   typedef struct packed {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
   } fb_req_t;

   function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
      return ((addr ^ base) & FB_WIN_MASK) == 32'h0;
   endfunction

endpackage

// File: rtl/flexbus_if.sv
// Request/response handshake between a client and the FlexBus master.
interface flexbus_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_rw;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   modport master (
      input  req_valid, req_rw, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   modport slave (
      output req_valid, req_rw, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );

endinterface

// File: rtl/flexbus_master.sv
// FlexBus multiplexed address/data master: one access at a time, ADDR -> DATA -> TURN.
// Bus pins are decoded from the state register so an async reset releases them at once.
module flexbus_master
   import flexbus_pkg::*;
#(
   parameter logic [31:0] FB_BASE     = FB_BASE_DEF,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        FB_CLK,
   input  logic        RST_n,
   flexbus_if.master   bus,
   output logic        FB_ALE,
   output logic        FB_CS,
   output logic        FB_RW,
   output logic        FB_OE,
   inout  wire  [31:0] FB_AD
);

   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   fb_req_t     req_q, req_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ad_oe;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: if (bus.req_valid) begin
            req_d = '{rw: bus.req_rw, addr: bus.req_addr, wdata: bus.req_wdata};
            if (in_window(bus.req_addr, FB_BASE)) begin
               state_d = ST_ADDR;
               err_d   = 1'b0;
            end else begin
               // Out-of-window: skip the bus entirely and report in TURN
               state_d = ST_TURN;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         ST_ADDR: begin
            state_d = ST_DATA;
            cnt_d   = WS_INIT;
         end
         ST_DATA: if (cnt_q == 4'd0) begin
            state_d = ST_TURN;
            rdata_d = req_q.rw ? FB_AD : 32'h0;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge FB_CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '{rw: 1'b1, addr: 32'h0, wdata: 32'h0};
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // AD is only ours in ADDR and write DATA; read DATA leaves it to the slave
   assign ad_oe  = (state_q == ST_ADDR) || ((state_q == ST_DATA) && !req_q.rw);
   assign FB_AD  = ad_oe ? ((state_q == ST_ADDR) ? req_q.addr : req_q.wdata) : 32'bz;
   assign FB_ALE = (state_q == ST_ADDR);
   assign FB_CS  = (state_q != ST_DATA);
   assign FB_RW  = req_q.rw;
   assign FB_OE  = !((state_q == ST_DATA) && req_q.rw);

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.resp_valid = (state_q == ST_TURN);
   assign bus.resp_err   = err_q && (state_q == ST_TURN);
   assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_flexbus_master.sv
// Self-checking bench for flexbus_master: directed table, random traffic against a
// register-map model, back-to-back requests, reset mid-read, WAIT_STATES 0 and 3.
module tb_flexbus_master;

   localparam int MAIN_WS = 1;

   logic FB_CLK;
   logic RST_n;
   int   n_chk;
   int   n_fail;
   int   cyc;

   initial FB_CLK = 1'b0;
   always #5 FB_CLK = ~FB_CLK;

   flexbus_if bus ();
   logic       fb_ale, fb_cs, fb_rw, fb_oe;
   wire [31:0] fb_ad;

   flexbus_master #(.FB_BASE(32'h6000_0000), .WAIT_STATES(MAIN_WS)) u_dut (
      .FB_CLK (FB_CLK),
      .RST_n  (RST_n),
      .bus    (bus),
      .FB_ALE (fb_ale),
      .FB_CS  (fb_cs),
      .FB_RW  (fb_rw),
      .FB_OE  (fb_oe),
      .FB_AD  (fb_ad)
   );

   function automatic logic [31:0] init_val(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0101;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Peripheral attached to the bus: 64 word registers decoded from addr[7:2]
   logic [31:0] slv_mem [64];
   logic [31:0] slv_addr;
   bit          slv_init;
   always @(posedge FB_CLK) begin
      if (!slv_init) begin
         for (int i = 0; i < 64; i++) slv_mem[i] <= init_val(i);
         slv_addr <= 32'h0;
         slv_init <= 1'b1;
      end else begin
         if (fb_ale) slv_addr <= fb_ad;
         if (!fb_cs && fb_oe && !fb_rw) slv_mem[slv_addr[7:2]] <= fb_ad;
      end
   end
   assign fb_ad = !fb_oe ? slv_mem[slv_addr[7:2]] : 32'bz;

   // Handshake log for spacing / ordering checks
   int          acc_log [$];
   logic [31:0] rsp_log [$];
   always @(posedge FB_CLK) begin
      if (bus.req_valid && bus.req_ready) acc_log.push_back(cyc);
      if (bus.resp_valid) rsp_log.push_back(bus.resp_rdata);
      cyc <= cyc + 1;
   end

   // Reference model of the register map as seen by the client
   logic [31:0] exp_mem [64];

   task automatic do_req(input string nm, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
      int lat, waitc, n_ale, n_cs, n_oe, n_bad;
      bit got;
      logic got_err;
      logic [31:0] got_rd;
      n_ale = 0; n_cs = 0; n_oe = 0; n_bad = 0; got = 0; got_err = 0; got_rd = 0;
      @(negedge FB_CLK);
      bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_addr = addr; bus.req_wdata = wd;
      waitc = 0;
      while (!bus.req_ready && waitc < 20) begin
         @(negedge FB_CLK);
         waitc++;
      end
      chk({nm, " ready"}, 32'(bus.req_ready), 32'd1);
      @(negedge FB_CLK);
      bus.req_valid = 1'b0; bus.req_rw = ~rw; bus.req_addr = $urandom; bus.req_wdata = $urandom;
      lat = 1;
      while (!got && lat <= 30) begin
         if (fb_ale) begin
            n_ale++;
            chk({nm, " AD addr"}, fb_ad, addr);
            if (fb_rw != rw) n_bad++;
         end
         if (!fb_cs) begin
            n_cs++;
            if (!rw) chk({nm, " AD wdata"}, fb_ad, wd);
            if (fb_rw != rw) n_bad++;
         end
         if (!fb_oe) begin
            n_oe++;
            if (fb_cs) n_bad++;
         end
         if (!fb_cs && fb_ale) n_bad++;
         if (bus.resp_valid) begin
            got = 1; got_err = bus.resp_err; got_rd = bus.resp_rdata;
         end else begin
            @(negedge FB_CLK);
            lat++;
         end
      end
      chk({nm, " resp_valid seen"}, 32'(got), 32'd1);
      chk({nm, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'(3 + MAIN_WS));
      chk({nm, " resp_err"}, 32'(got_err), 32'(exp_err));
      chk({nm, " resp_rdata"}, got_rd, exp_rd);
      chk({nm, " ALE cycles"}, 32'(n_ale), exp_err ? 32'd0 : 32'd1);
      chk({nm, " CS cycles"}, 32'(n_cs), exp_err ? 32'd0 : 32'(1 + MAIN_WS));
      chk({nm, " OE cycles"}, 32'(n_oe), (exp_err || !rw) ? 32'd0 : 32'(1 + MAIN_WS));
      chk({nm, " bus rule violations"}, 32'(n_bad), 32'd0);
      @(negedge FB_CLK);
      chk({nm, " resp_valid one cycle"}, 32'(bus.resp_valid), 32'd0);
      chk({nm, " rdata held"}, bus.resp_rdata, exp_rd);
   endtask

   task automatic model_req(input string nm, input logic rw, input logic [31:0] a, input logic [31:0] wd);
      logic ok;
      logic [31:0] exp;
      ok  = (a[31:28] == 4'h6);
      exp = (ok && rw) ? exp_mem[a[7:2]] : 32'h0;
      do_req(nm, rw, a, wd, !ok, exp);
      if (ok && !rw) exp_mem[a[7:2]] = wd;
   endtask

   // Second and third DUTs exercise the extreme wait-state settings
   for (genvar g = 0; g < 2; g++) begin : g_aux
      localparam int unsigned WS = (g == 0) ? 0 : 3;
      flexbus_if   abus ();
      wire [31:0]  a_ad;
      logic        a_rst_n, a_ale, a_cs, a_rw, a_oe;
      logic [31:0] a_lat, a_led;
      bit          done;

      flexbus_master #(.FB_BASE(32'h6000_0000), .WAIT_STATES(WS)) u_dut (
         .FB_CLK (FB_CLK),
         .RST_n  (a_rst_n),
         .bus    (abus),
         .FB_ALE (a_ale),
         .FB_CS  (a_cs),
         .FB_RW  (a_rw),
         .FB_OE  (a_oe),
         .FB_AD  (a_ad)
      );

      always @(posedge FB_CLK) begin
         if (a_ale) a_lat <= a_ad;
         if (!a_cs && a_oe && !a_rw && a_lat[7:2] == 6'd0) a_led <= a_ad;
      end

      initial begin
         int lat, ncs;
         bit got;
         a_rst_n = 1'b1;
         abus.req_valid = 1'b0; abus.req_rw = 1'b0; abus.req_addr = 32'h0; abus.req_wdata = 32'h0;
         #1 a_rst_n = 1'b0;
         repeat (3) @(negedge FB_CLK);
         a_rst_n = 1'b1;
         @(negedge FB_CLK);
         abus.req_valid = 1'b1; abus.req_addr = 32'h6000_0000; abus.req_wdata = 32'hA5A5_A5A5;
         @(negedge FB_CLK);
         abus.req_valid = 1'b0;
         lat = 1; ncs = 0; got = 0;
         while (!got && lat <= 30) begin
            if (!a_cs) ncs++;
            if (abus.resp_valid) got = 1;
            else begin
               @(negedge FB_CLK);
               lat++;
            end
         end
         chk($sformatf("ws%0d resp_valid seen", WS), 32'(got), 32'd1);
         chk($sformatf("ws%0d latency", WS), 32'(lat), 32'(3 + WS));
         chk($sformatf("ws%0d DATA cycles", WS), 32'(ncs), 32'(1 + WS));
         chk($sformatf("ws%0d resp_err", WS), 32'(abus.resp_err), 32'd0);
         @(negedge FB_CLK);
         chk($sformatf("ws%0d LED_FREQ_Qout", WS), a_led, 32'hA5A5_A5A5);
         done = 1'b1;
      end
   end

   typedef struct {
      string       nm;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   initial begin
      vec_t        tab [$];
      logic        rw;
      logic [31:0] a, wd;
      logic [31:0] b2b_exp [3];
      int          waitc, ab, rb;

      n_chk = 0; n_fail = 0; cyc = 0;
      for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
      RST_n = 1'b1;
      bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      #1 RST_n = 1'b0;
      repeat (3) @(negedge FB_CLK);

      chk("rst FB_ALE", 32'(fb_ale), 32'd0);
      chk("rst FB_CS", 32'(fb_cs), 32'd1);
      chk("rst FB_RW", 32'(fb_rw), 32'd1);
      chk("rst FB_OE", 32'(fb_oe), 32'd1);
      chk("rst req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst resp_rdata", bus.resp_rdata, 32'h0);
      RST_n = 1'b1;

      tab.push_back('{"wr BZ_FREQ",   1'b0, 32'h6000_0004, 32'h0000_03E8, 1'b0, 32'h0});
      tab.push_back('{"wr LEDR",      1'b0, 32'h6000_0008, 32'h1234_5678, 1'b0, 32'h0});
      tab.push_back('{"rd LEDR",      1'b1, 32'h6000_0008, 32'h0,         1'b0, 32'h1234_5678});
      tab.push_back('{"rd outside",   1'b1, 32'h7000_0000, 32'h0,         1'b1, 32'h0});
      tab.push_back('{"wr LED_FREQ",  1'b0, 32'h6000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0});
      tab.push_back('{"rd BZ_FREQ",   1'b1, 32'h6000_0004, 32'h0,         1'b0, 32'h0000_03E8});
      tab.push_back('{"wr below win", 1'b0, 32'h5FFF_FFFC, 32'hDEAD_BEEF, 1'b1, 32'h0});
      tab.push_back('{"rd top of win",1'b1, 32'h6FFF_FFFC, 32'h0,         1'b0, 32'hC0DE_3F3F});
      tab.push_back('{"rd LEDG",      1'b1, 32'h6000_000C, 32'h0,         1'b0, 32'hC0DE_0303});

      foreach (tab[i]) begin
         do_req(tab[i].nm, tab[i].rw, tab[i].addr, tab[i].wdata, tab[i].err, tab[i].rdata);
         if (!tab[i].err && !tab[i].rw) exp_mem[tab[i].addr[7:2]] = tab[i].wdata;
      end
      chk("BZ_FREQ_Qout", slv_mem[1], 32'h0000_03E8);
      chk("LED_FREQ_Qout", slv_mem[0], 32'hA5A5_A5A5);
      chk("reg 63 untouched by rejected write", slv_mem[63], 32'hC0DE_3F3F);

      for (int k = 0; k < 40; k++) begin
         rw = 1'($urandom_range(0, 1));
         wd = $urandom;
         a  = {4'h6, 20'h0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 9) < 3) a[31:28] = 4'($urandom_range(0, 15));
         model_req($sformatf("rnd%0d", k), rw, a, wd);
         repeat ($urandom_range(0, 2)) @(negedge FB_CLK);
      end

      // Three reads presented with req_valid held high throughout
      for (int k = 0; k < 3; k++) b2b_exp[k] = exp_mem[k];
      ab = acc_log.size();
      rb = rsp_log.size();
      @(negedge FB_CLK);
      bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 32'h6000_0000;
      for (int k = 0; k < 3; k++) begin
         waitc = 0;
         while (acc_log.size() <= ab + k && waitc < 40) begin
            @(negedge FB_CLK);
            waitc++;
         end
         if (k < 2) bus.req_addr = 32'h6000_0000 + 32'(4 * (k + 1));
         else bus.req_valid = 1'b0;
      end
      waitc = 0;
      while (rsp_log.size() < rb + 3 && waitc < 60) begin
         @(negedge FB_CLK);
         waitc++;
      end
      repeat (8) @(negedge FB_CLK);
      chk("b2b accept count", 32'(acc_log.size() - ab), 32'd3);
      chk("b2b resp count", 32'(rsp_log.size() - rb), 32'd3);
      if (acc_log.size() >= ab + 3) begin
         chk("b2b spacing 1", 32'(acc_log[ab+1] - acc_log[ab]), 32'(4 + MAIN_WS));
         chk("b2b spacing 2", 32'(acc_log[ab+2] - acc_log[ab+1]), 32'(4 + MAIN_WS));
      end
      if (rsp_log.size() >= rb + 3)
         for (int k = 0; k < 3; k++) chk($sformatf("b2b rdata %0d", k), rsp_log[rb+k], b2b_exp[k]);

      // Reset dropped during a read DATA cycle
      @(negedge FB_CLK);
      bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 32'h6000_0008;
      @(negedge FB_CLK);
      bus.req_valid = 1'b0;
      waitc = 0;
      while (fb_oe && waitc < 10) begin
         @(negedge FB_CLK);
         waitc++;
      end
      chk("abort reached read DATA", 32'(fb_oe), 32'd0);
      rb = rsp_log.size();
      #2 RST_n = 1'b0;
      #1;
      chk("abort FB_CS", 32'(fb_cs), 32'd1);
      chk("abort FB_OE", 32'(fb_oe), 32'd1);
      chk("abort FB_ALE", 32'(fb_ale), 32'd0);
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort req_ready", 32'(bus.req_ready), 32'd1);
      chk("abort resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("abort resp_rdata", bus.resp_rdata, 32'h0);
      repeat (2) @(negedge FB_CLK);
      RST_n = 1'b1;
      repeat (3) @(negedge FB_CLK);
      chk("abort no response", 32'(rsp_log.size() - rb), 32'd0);
      model_req("rd after abort", 1'b1, 32'h6000_0008, 32'h0);

      waitc = 0;
      while (!(g_aux[0].done && g_aux[1].done) && waitc < 200) begin
         @(negedge FB_CLK);
         waitc++;
      end
      chk("aux instances finished", 32'(g_aux[0].done && g_aux[1].done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1);
   end

endmodule
